seq_divider_32bit: RTL and testbench



---
 rtl/seq_divider_32bit.sv | 139 +++++++++++++
 tb/tb_seq_divider_32bit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32bit.sv
// Multi-cycle restoring divider: one quotient bit per clock, WIDTH+1-bit trial subtract.
// Define SEQ_DIVIDER_SIGNED_DIV_EN to add the signed_op port (two's-complement division).
module seq_divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [1:0]       o_dbg_state
);

  // Handshake: start is accepted on a rising edge whenever busy=0 (IDLE or DONE);
  // done pulses for one cycle with results, which then hold until the next accepted start.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_quot_res;
  logic [WIDTH-1:0] w_rem_res;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_cnt == LAST);

  assign w_t      = {r_r, r_q[WIDTH-1]};
  assign w_diff   = w_t - {1'b0, r_d};
  assign w_fits   = ~w_diff[WIDTH];
  assign w_q_next = {r_q[WIDTH-2:0], w_fits};
  // A failed trial leaves T < D, so T always fits back into WIDTH bits.
  assign w_r_next = w_fits ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];

`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg = signed_op & dividend[WIDTH-1];
  assign w_b_neg = signed_op & divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag = w_b_neg ? (~divisor + 1'b1) : divisor;
  // Most-negative / -1 wraps back to most-negative through this negation.
  assign w_quot_res = r_neg_q ? (~w_q_next + 1'b1) : w_q_next;
  assign w_rem_res  = r_neg_r ? (~w_r_next + 1'b1) : w_r_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  assign w_a_mag    = dividend;
  assign w_b_mag    = divisor;
  assign w_quot_res = w_q_next;
  assign w_rem_res  = w_r_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_q   <= w_a_mag;
      r_r   <= '0;
      r_d   <= w_b_mag;
      r_cnt <= '0;
      if (divisor == '0) begin
        r_state     <= S_DONE;
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_dbz       <= 1'b1;
      end else begin
        r_state     <= S_RUN;
        r_quotient  <= '0;
        r_remainder <= '0;
        r_dbz       <= 1'b0;
      end
    end else if (r_state == S_RUN) begin
      r_q   <= w_q_next;
      r_r   <= w_r_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_state     <= S_DONE;
        r_quotient  <= w_quot_res;
        r_remainder <= w_rem_res;
      end
    end else begin
      r_state <= S_IDLE;
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Directed bench for seq_divider_32bit: driver pushes expected results, a negedge monitor checks them.
module tb_seq_divider_32bit;
  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [1:0]   dbg_state;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
  logic         signed_op;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic         exp_z[$];
  int           exp_lat[$];
  int           exp_st[$];

  seq_divider_32bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    .signed_op   (signed_op),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        logic [W-1:0] eq, er;
        logic         ez;
        int           el, est;
        eq  = exp_q.pop_front();
        er  = exp_r.pop_front();
        ez  = exp_z.pop_front();
        el  = exp_lat.pop_front();
        est = exp_st.pop_front();
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", W'(div_by_zero), W'(ez));
        chk("busy_at_done", W'(busy), '0);
        chk("latency", W'(cyc - est + 1), W'(el));
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    @(negedge clk);
    dividend = a;
    divisor  = b;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    signed_op = sgn;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(eq);
    exp_r.push_back(er);
    exp_z.push_back(ez);
    exp_lat.push_back((b == '0) ? 1 : W + 1);
    exp_st.push_back(cyc);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s actual=%0d pending expected=0", name, exp_q.size());
      exp_q.delete(); exp_r.delete(); exp_z.delete(); exp_lat.delete(); exp_st.delete();
    end
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    signed_op = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_quotient", quotient, '0);
    chk("rst_remainder", remainder, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_dbz", W'(div_by_zero), '0);
    reset = 1'b0;
    @(negedge clk);

    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    repeat (4) @(negedge clk);
    chk("busy_in_run", W'(busy), 32'd1);
    wait_idle("100_7");

    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    wait_idle("max_1");
    issue(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
    wait_idle("5_9");
    repeat (5) @(negedge clk);
    chk("hold_quotient", quotient, 32'd0);
    chk("hold_remainder", remainder, 32'd5);

    issue(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    wait_idle("div0");
    issue(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0);
    wait_idle("after_div0");

    // start while busy is ignored; start in the DONE cycle is accepted
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    repeat (7) @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout_b2b actual=0 expected=1");
    end else begin
      dividend = 32'd50;
      divisor  = 32'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(32'd10);
      exp_r.push_back(32'd0);
      exp_z.push_back(1'b0);
      exp_lat.push_back(W + 1);
      exp_st.push_back(cyc);
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle("b2b");

    // reset mid-run aborts with no done pulse
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    exp_q.delete(); exp_r.delete(); exp_z.delete(); exp_lat.delete(); exp_st.delete();
    #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_quotient", quotient, '0);
    chk("abort_remainder", remainder, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0);
    wait_idle("after_abort");

`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    wait_idle("s_m7_2");
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    wait_idle("s_7_m2");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    wait_idle("s_ovf");
    issue(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    wait_idle("s_div0");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
